fetch_memory: RTL

Parametrised instruction-fetch memory for the single-cycle/multi-cycle CPU core. Byte-addressed, word-organised storage with a valid/ready request channel from the PC stage, a registered response channel with configurable wait states, alignment/range error reporting, and a write-only load port for program download. Supersedes the combinational instruction ROM in the fetch path.

---
 rtl/fetch_memory.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fetch_memory.sv
// fetch_memory: word-organised instruction fetch memory with a load port.
// Define FETCH_MEM_PRELOAD_EN to power up holding the three-word boot program.
module fetch_memory #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data
);

    localparam int OFF = $clog2(DATA_W / 8);
    localparam int IW  = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << OFF) - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

`ifdef FETCH_MEM_PRELOAD_EN
    localparam bit PRELOAD = 1'b1;
`else
    localparam bit PRELOAD = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state, state_n;

    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              rsp_load;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_word;
    logic [ADDR_W-1:0] ld_word;
    logic              rd_ok;
    logic              ld_ok;
    logic [IW-1:0]     rd_idx;
    logic [IW-1:0]     ld_idx;

    // The array holds data XOR boot image, so a zeroed array reads back
    // as the boot program without needing an init file.
    function automatic logic [DATA_W-1:0] boot_word(input logic [IW-1:0] i);
        logic [31:0] w;
        w = '0;
        if (PRELOAD) begin
            if (int'(i) == 0)      w = 32'h003100B3;
            else if (int'(i) == 1) w = 32'h00308233;
            else if (int'(i) == 2) w = 32'h401202B3;
        end
        return DATA_W'(w);
    endfunction

    // In IDLE the live request address feeds the read for zero-wait entry.
    assign rd_addr = (state == S_IDLE) ? req_addr : addr_q;
    assign rd_word = rd_addr >> OFF;
    assign ld_word = load_addr >> OFF;
    assign rd_ok   = ~|(rd_addr & LOW_MASK) && (rd_word < DEPTH_A);
    assign ld_ok   = ~|(load_addr & LOW_MASK) && (ld_word < DEPTH_A);
    assign rd_idx  = rd_word[IW-1:0];
    assign ld_idx  = ld_word[IW-1:0];

    assign accept   = req_valid && (state == S_IDLE);
    assign rsp_load = (state_n == S_RESP) && (state != S_RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd1) begin
                    state_n = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == S_IDLE) && !rst;
        rsp_valid = (state == S_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            cnt      <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= req_addr;
                cnt    <= 4'(WAIT_CYCLES);
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (rsp_load) begin
                rsp_err  <= !rd_ok;
                rsp_data <= rd_ok ? (mem[rd_idx] ^ boot_word(rd_idx)) : '0;
            end
        end
    end

    // Nonblocking write gives read-before-write on a same-edge collision.
    always_ff @(posedge clk) begin
        if (load_en && ld_ok) begin
            mem[ld_idx] <= load_data ^ boot_word(ld_idx);
        end
    end

endmodule
